// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM macro between a write requester and a read requester.
// Fills the array with INIT_VAL after reset, then grants round-robin; read data is queued in a small FIFO.
module sram_sp_arbiter #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VAL   = '0,
  parameter int                RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q
);

  localparam int                CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int                PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RESP_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

  state_t            state_reg, state_next;
  prio_t             prio_reg, prio_next;
  logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;
  logic              inflight_reg;

  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              r_ok;
  logic              r_grant;
  logic              w_grant;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W:0]    credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits count both queued data and the read whose Q arrives this cycle,
  // so a granted read always finds a free FIFO slot when its data lands.
  assign credit_used = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg);
  assign r_ok        = (credit_used < CREDIT_MAX);

  assign init_done  = !reset && (state_reg == ST_RUN);
  assign resp_valid = !reset && (count_reg != '0);
  assign resp_data  = resp_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign fifo_push  = inflight_reg;
  assign fifo_pop   = resp_valid && resp_ready;

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    prio_next     = prio_reg;
    w_ready       = 1'b0;
    r_ready       = 1'b0;
    w_grant       = 1'b0;
    r_grant       = 1'b0;
    sram_CEB      = 1'b1;
    sram_WEB      = 1'b1;
    sram_A        = '0;
    sram_D        = '0;

    if (!reset) begin
      case (state_reg)
        ST_INIT: begin
          sram_CEB      = 1'b0;
          sram_WEB      = 1'b0;
          sram_A        = init_cnt_reg;
          sram_D        = INIT_VAL;
          init_cnt_next = init_cnt_reg + ADDR_W'(1);
          if (init_cnt_reg == LAST_ADDR) begin
            state_next = ST_RUN;
          end
        end

        ST_RUN: begin
          r_ready = r_ok && (!w_valid || (prio_reg == PRIO_READ));
          w_ready = !(r_valid && r_ok) || (prio_reg == PRIO_WRITE);
          r_grant = r_valid && r_ready;
          w_grant = w_valid && w_ready && !r_grant;

          if (r_grant) begin
            sram_CEB  = 1'b0;
            sram_WEB  = 1'b1;
            sram_A    = r_addr;
            prio_next = PRIO_WRITE;
          end else if (w_grant) begin
            sram_CEB  = 1'b0;
            sram_WEB  = 1'b0;
            sram_A    = w_addr;
            sram_D    = w_data;
            prio_next = PRIO_READ;
          end
        end

        default: begin
          state_next = ST_INIT;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (fifo_push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (fifo_pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (fifo_push && !fifo_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      prio_reg     <= PRIO_READ;
      init_cnt_reg <= '0;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      prio_reg     <= prio_next;
      init_cnt_reg <= init_cnt_next;
      inflight_reg <= r_grant;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Macro Q is only meaningful in the cycle after a read, so capture it exactly then.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= sram_Q;
    end
  end

  overflow_check: assert property (@(posedge clock) disable iff (reset)
    !(fifo_push && !fifo_pop && (count_reg == CNT_FULL)));

endmodule
